conv1d_transpose_3tap_s2: RTL and testbench
===========================================

// Module: conv1d_transpose_3tap_s2
// PURPOSE
//   Stride-2 transposed 1D convolution with a 3-tap kernel, for upsampling on the decoder side.
//   It is the inverse-direction companion of the 3-tap forward convolution stage.
//   Consumes 8-bit unsigned samples in frames and emits 2N+1 signed results per N-sample frame.
//   Both sides use valid/ready streaming handshakes with full backpressure.
// PARAMETERS
//   K0     8'sd1   signed 8-bit kernel tap 0
//   K1     8'sd2   signed 8-bit kernel tap 1
//   K2     8'sd1   signed 8-bit kernel tap 2
//   OUT_W  18      output width, two's complement; must be >= 18
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      reset, asynchronous, active-high
//   in_data    in   8      input sample x[n], unsigned
//   in_valid   in   1      in_data/in_last valid
//   in_last    in   1      marks the final sample of a frame
//   in_ready   out  1      block accepts a sample this cycle
//   out_data   out  OUT_W  result y[m], signed
//   out_valid  out  1      out_data/out_last valid
//   out_last   out  1      marks the final result of a frame (tail output)
//   out_ready  in   1      downstream accepts out_data this cycle
// BEHAVIOUR
//   Math: y[2n] = K0*x[n] + K2*x[n-1]; y[2n+1] = K1*x[n]; tail y[2N] = K2*x[N-1].
//     x[-1] = 0 at every frame start.
//     Products are sign-extended to OUT_W before the sum; the result never saturates or wraps.
//   Output slot is a single register.
//     "Slot free" = !out_valid || out_ready.
//     out_data, out_valid and out_last hold stable while out_valid && !out_ready.
//   in_ready = (state==S_IN) && slot free. This is combinational from state, out_valid and out_ready.
//   Internal registers:
//     x_cur: latched sample
//     x_prev: previous sample, 0 at frame start
//     last_f: latched in_last
//   States:
//     S_IN: on in_valid && in_ready:
//       out_data <= K0*in_data + K2*x_prev; out_valid <= 1; out_last <= 0;
//       x_prev <= in_data; x_cur <= in_data; last_f <= in_last; -> S_ODD.
//       Else, if out_ready, out_valid <= 0.
//     S_ODD: when slot free:
//       out_data <= K1*x_cur; out_valid <= 1; out_last <= 0;
//       -> S_TAIL if last_f, else -> S_IN.
//     S_TAIL: when slot free:
//       out_data <= K2*x_cur; out_valid <= 1; out_last <= 1; x_prev <= 0; -> S_IN.
//   Latency: a sample accepted at edge t gives its even result visible after edge t.
//     The odd result follows at t+1 if out_ready=1.
//   Throughput: 1 result/cycle with out_ready held high.
//     One sample is taken every 2 cycles, and every 3 cycles for a last sample.
//   in_valid while in_ready=0 is ignored; the source must hold its data.
//   A single-sample frame (in_last on first sample) yields 3 results: K0*x, K1*x, K2*x(last).
//   Reset, including mid-frame, gives immediately:
//     state=S_IN, out_valid=0, out_last=0, out_data=0, x_cur=0, x_prev=0, last_f=0.
//     The partial frame is discarded and the next sample starts a new frame.
// TESTING
//   1. Defaults; frame x=10,20,30 (last on 30), out_ready=1
//      -> 10,20,30,40,50,60,30; out_last only on the final 30.
//   2. K0=-128,K1=127,K2=-128; frame x=255,255(last)
//      -> -32640,32385,-65280,32385,-32640 (OUT_W=18, no wrap).
//   3. Frame 10,20,30 with out_ready random ~50%
//      -> identical sequence; out_data stable while stalled; in_ready=0 during stalls.
//   4. Two back-to-back frames 5(last) then 7(last)
//      -> 5,10,5(last),7,14,7(last); the second frame gets no x_prev carry-over.
//   5. Reset asserted after y1 of frame 10,20,...; then frame 4(last)
//      -> outputs drop to 0 at once; then 4,8,4(last).
//   6. in_valid held high continuously with out_ready=1
//      -> in_ready pattern 1,0 (1,0,0 around last); no sample is lost or duplicated.

Source files
------------

// File: rtl/conv1d_transpose_3tap_s2.sv
// Stride-2 transposed 1D convolution, 3-tap kernel: each input sample x[n] yields an even
// result K0*x[n]+K2*x[n-1] and an odd result K1*x[n]; a frame ends with a K2*x[N-1] tail.
module conv1d_transpose_3tap_s2 #(
  parameter logic signed [7:0] K0    = 8'sd1,
  parameter logic signed [7:0] K1    = 8'sd2,
  parameter logic signed [7:0] K2    = 8'sd1,
  parameter int unsigned       OUT_W = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
);

  if (OUT_W < 18) begin : g_out_w_check
    $error("OUT_W must be at least 18");
  end

  typedef enum logic [1:0] {S_IN, S_ODD, S_TAIL} state_t;

  state_t           state, state_d;
  logic [7:0]       x_cur, x_cur_d;
  logic [7:0]       x_prev, x_prev_d;
  logic             last_f, last_f_d;
  logic [OUT_W-1:0] out_data_d;
  logic             out_valid_d, out_last_d;
  logic             slot_free, accept;

  // Signed tap times unsigned sample, sign-extended to the full output width.
  function automatic logic signed [OUT_W-1:0] tap(input logic signed [7:0] k,
                                                  input logic [7:0] x);
    logic signed [16:0] ke, xe, p;
    ke = 17'(k);
    xe = 17'($signed({1'b0, x}));
    p  = ke * xe;
    return OUT_W'(p);
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == S_IN) && slot_free;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IN;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IN:    if (accept) state_d = S_ODD;
      S_ODD:   if (slot_free) state_d = last_f ? S_TAIL : S_IN;
      S_TAIL:  if (slot_free) state_d = S_IN;
      default: state_d = S_IN;
    endcase
  end

  always_comb begin
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    x_cur_d     = x_cur;
    x_prev_d    = x_prev;
    last_f_d    = last_f;
    case (state)
      S_IN: begin
        if (accept) begin
          out_data_d  = tap(K0, in_data) + tap(K2, x_prev);
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          x_prev_d    = in_data;
          x_cur_d     = in_data;
          last_f_d    = in_last;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      S_ODD: begin
        if (slot_free) begin
          out_data_d  = tap(K1, x_cur);
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
        end
      end
      S_TAIL: begin
        // Clearing x_prev here makes the next frame start with x[-1] = 0.
        if (slot_free) begin
          out_data_d  = tap(K2, x_cur);
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          x_prev_d    = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      x_cur     <= '0;
      x_prev    <= '0;
      last_f    <= 1'b0;
    end else begin
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      x_cur     <= x_cur_d;
      x_prev    <= x_prev_d;
      last_f    <= last_f_d;
    end
  end

endmodule

// File: tb/tb_conv1d_transpose_3tap_s2.sv
// Directed bench for conv1d_transpose_3tap_s2: default kernel instance plus an extreme-kernel instance.
module tb_conv1d_transpose_3tap_s2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  in_data, in2_data;
  logic        in_valid, in_last, in_ready, in2_valid, in2_last, in2_ready;
  logic [17:0] out_data, out2_data;
  logic        out_valid, out_last, out2_valid, out2_last;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_rdy = 1'b0;

  logic signed [17:0] qd1[$];
  logic signed [17:0] qd2[$];
  bit                 ql1[$];
  bit                 ql2[$];

  bit          stall1;
  logic [17:0] hold_d;
  logic        hold_l;

  conv1d_transpose_3tap_s2 #(.OUT_W(18)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );

  conv1d_transpose_3tap_s2 #(.K0(8'sh80), .K1(8'sh7F), .K2(8'sh80), .OUT_W(18)) dut_k (
    .clk(clk), .reset(reset),
    .in_data(in2_data), .in_valid(in2_valid), .in_last(in2_last), .in_ready(in2_ready),
    .out_data(out2_data), .out_valid(out2_valid), .out_last(out2_last), .out_ready(out_ready)
  );

  // Downstream ready: constant 1, or random while rand_rdy is set.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: collects handshaken results and checks stall behaviour.
  initial begin
    stall1 = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall1 = 1'b0;
      end else begin
        if (stall1) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l) begin
            n_bad++;
            $display("FAIL stall_hold: valid=%b data=%0d last=%b, required 1/%0d/%b",
                     out_valid, $signed(out_data), out_last, $signed(hold_d), hold_l);
          end
        end
        if (out_valid && !out_ready) begin
          n_cmp++;
          if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_in_ready: in_ready=%b, required 0", in_ready);
          end
        end
        if (out_valid && out_ready) begin
          qd1.push_back($signed(out_data));
          ql1.push_back(out_last);
        end
        stall1 = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
        if (out2_valid && out_ready) begin
          qd2.push_back($signed(out2_data));
          ql2.push_back(out2_last);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready=%b for sample %0d, required 1", in_ready, d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_q1(input int n);
    int t;
    t = 0;
    while (qd1.size() < n && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (qd1.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL result_timeout: got %0d results, required %0d", qd1.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    repeat (4) @(posedge clk);
    #1;
    qd1.delete(); ql1.delete(); qd2.delete(); ql2.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%b last=%b data=%0d, required 0/0/0",
               out_valid, out_last, out_data);
    end
    n_cmp++;
    if (out2_valid !== 1'b0 || out2_data !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_outputs_k: valid=%b data=%0d, required 0/0", out2_valid, out2_data);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic_frame();
    int exp_d[7] = '{10, 20, 30, 40, 50, 60, 30};
    idle();
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b1);
    wait_q1(7);
    n_cmp++;
    if (qd1.size() != 7) begin
      n_bad++;
      $display("FAIL basic_count: %0d results, required 7", qd1.size());
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (i >= qd1.size() || qd1[i] !== exp_d[i] || ql1[i] !== (i == 6)) begin
        n_bad++;
        $display("FAIL basic_y%0d: got %0d last=%b, required %0d last=%b", i,
                 (i < qd1.size()) ? int'(qd1[i]) : -1, (i < ql1.size()) ? ql1[i] : 1'b0,
                 exp_d[i], (i == 6));
      end
    end
  endtask

  task automatic test_extreme_kernel();
    int exp_d[5] = '{-32640, 32385, -65280, 32385, -32640};
    int t;
    idle();
    for (int s = 0; s < 2; s++) begin
      in2_data  = 8'd255;
      in2_last  = (s == 1);
      in2_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        #1;
        t++;
      end while (!in2_ready && t < 200);
      if (!in2_ready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extreme_send_timeout: in_ready=%b, required 1", in2_ready);
      end
      @(posedge clk);
      #1;
      in2_valid = 1'b0;
    end
    t = 0;
    while (qd2.size() < 5 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (qd2.size() != 5) begin
      n_bad++;
      $display("FAIL extreme_count: %0d results, required 5", qd2.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= qd2.size() || qd2[i] !== exp_d[i] || ql2[i] !== (i == 4)) begin
        n_bad++;
        $display("FAIL extreme_y%0d: got %0d last=%b, required %0d last=%b", i,
                 (i < qd2.size()) ? int'(qd2[i]) : -1, (i < ql2.size()) ? ql2[i] : 1'b0,
                 exp_d[i], (i == 4));
      end
    end
  endtask

  task automatic test_random_stall();
    int exp_d[7] = '{10, 20, 30, 40, 50, 60, 30};
    idle();
    rand_rdy = 1'b1;
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b1);
    wait_q1(7);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (qd1.size() != 7) begin
      n_bad++;
      $display("FAIL stall_count: %0d results, required 7", qd1.size());
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (i >= qd1.size() || qd1[i] !== exp_d[i] || ql1[i] !== (i == 6)) begin
        n_bad++;
        $display("FAIL stall_y%0d: got %0d last=%b, required %0d last=%b", i,
                 (i < qd1.size()) ? int'(qd1[i]) : -1, (i < ql1.size()) ? ql1[i] : 1'b0,
                 exp_d[i], (i == 6));
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_d[6] = '{5, 10, 5, 7, 14, 7};
    bit exp_l[6] = '{0, 0, 1, 0, 0, 1};
    idle();
    send(8'd5, 1'b1);
    send(8'd7, 1'b1);
    wait_q1(6);
    n_cmp++;
    if (qd1.size() != 6) begin
      n_bad++;
      $display("FAIL b2b_count: %0d results, required 6", qd1.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i >= qd1.size() || qd1[i] !== exp_d[i] || ql1[i] !== exp_l[i]) begin
        n_bad++;
        $display("FAIL b2b_y%0d: got %0d last=%b, required %0d last=%b", i,
                 (i < qd1.size()) ? int'(qd1[i]) : -1, (i < ql1.size()) ? ql1[i] : 1'b0,
                 exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int exp_d[3] = '{4, 8, 4};
    int t;
    idle();
    send(8'd10, 1'b0);
    in_data  = 8'd20;
    in_last  = 1'b0;
    in_valid = 1'b1;
    t = 0;
    while (qd1.size() < 2 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 18'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_outputs: valid=%b last=%b data=%0d in_ready=%b, required 0/0/0/1",
               out_valid, out_last, out_data, in_ready);
    end
    n_cmp++;
    if (qd1.size() != 2 || qd1[0] !== 10 || qd1[1] !== 20) begin
      n_bad++;
      $display("FAIL midreset_prefix: %0d results, required 2 (10,20)", qd1.size());
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    qd1.delete();
    ql1.delete();
    send(8'd4, 1'b1);
    wait_q1(3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= qd1.size() || qd1[i] !== exp_d[i] || ql1[i] !== (i == 2)) begin
        n_bad++;
        $display("FAIL midreset_y%0d: got %0d last=%b, required %0d last=%b", i,
                 (i < qd1.size()) ? int'(qd1[i]) : -1, (i < ql1.size()) ? ql1[i] : 1'b0,
                 exp_d[i], (i == 2));
      end
    end
  endtask

  task automatic test_continuous_valid();
    logic [7:0] seq[5]    = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9};
    bit         lst[5]    = '{0, 0, 0, 1, 1};
    bit         exp_r[12] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0};
    int         exp_d[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 4, 9, 18, 9};
    bit         exp_l[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    bit         rdy_log[12];
    bit         acc;
    int         k;
    idle();
    k        = 0;
    in_data  = seq[0];
    in_last  = lst[0];
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      rdy_log[c] = in_ready;
      acc = in_ready && in_valid;
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k < 5) begin
          in_data = seq[k];
          in_last = lst[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_cmp++;
      if (rdy_log[c] !== exp_r[c]) begin
        n_bad++;
        $display("FAIL cont_in_ready_c%0d: in_ready=%b, required %b", c, rdy_log[c], exp_r[c]);
      end
    end
    n_cmp++;
    if (k != 5) begin
      n_bad++;
      $display("FAIL cont_accepted: %0d samples taken, required 5", k);
    end
    wait_q1(12);
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= qd1.size() || qd1[i] !== exp_d[i] || ql1[i] !== exp_l[i]) begin
        n_bad++;
        $display("FAIL cont_y%0d: got %0d last=%b, required %0d last=%b", i,
                 (i < qd1.size()) ? int'(qd1[i]) : -1, (i < ql1.size()) ? ql1[i] : 1'b0,
                 exp_d[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in2_data  = '0;
    in2_valid = 1'b0;
    in2_last  = 1'b0;
    test_reset();
    test_basic_frame();
    test_extreme_kernel();
    test_random_stall();
    test_back_to_back();
    test_reset_mid_frame();
    test_continuous_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
